// File: rtl/ram_be_sync_pkg.sv
// Shared types and constants for the byte-enabled synchronous RAM.
package ram_be_sync_pkg;

  localparam int unsigned LaneW = 8;

  typedef enum logic {
    StClear,
    StIdle
  } state_e;

endpackage

// File: rtl/ram_be_sync_lane.sv
// One byte lane of storage: DEPTH x 8 bits, synchronous write, combinational read.
module ram_be_sync_lane
  import ram_be_sync_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [LaneW-1:0] wdata,
  output logic [LaneW-1:0] rdata
);

  logic [LaneW-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ram_be_sync.sv
// Single-port synchronous RAM with byte-lane enables, req/ready handshake, registered read,
// out-of-range error pulse and an optional zeroing sweep after reset.
module ram_be_sync
  import ram_be_sync_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned ADDR_W         = 32,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req,
  input  logic                     rw,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W/LaneW-1:0]  en,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rvalid,
  output logic                     err,
  output logic                     ready
);

  localparam int unsigned LANES = DATA_W / LaneW;
  localparam int unsigned AW    = $clog2(DEPTH);

  state_e            state_q;
  logic [AW-1:0]     clr_ptr_q;
  logic              ready_q;
  logic              rvalid_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic              accept;
  logic              in_range;
  logic              clearing;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] lane_rd;
  logic [DATA_W-1:0] rd_masked;

  assign accept   = req && ready_q;
  // Full-width compare so upper address bits can never alias into the array.
  assign in_range = addr < ADDR_W'(DEPTH);
  assign clearing = (state_q == StClear) && !reset;
  assign mem_addr = clearing ? clr_ptr_q : addr[AW-1:0];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic             lane_we;
    logic [LaneW-1:0] lane_wd;

    assign lane_we = clearing || (accept && rw && in_range && en[i]);
    assign lane_wd = clearing ? '0 : wdata[i*LaneW +: LaneW];

    ram_be_sync_lane #(
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_lane (
      .clock (clock),
      .we    (lane_we),
      .addr  (mem_addr),
      .wdata (lane_wd),
      .rdata (lane_rd[i*LaneW +: LaneW])
    );
  end

  always_comb begin
    rd_masked = '0;
    for (int i = 0; i < LANES; i++) begin
      if (en[i]) begin
        rd_masked[i*LaneW +: LaneW] = lane_rd[i*LaneW +: LaneW];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= CLEAR_ON_RESET ? StClear : StIdle;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        StClear: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == AW'(DEPTH - 1)) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
          end
        end
        StIdle: begin
          ready_q <= 1'b1;
          if (accept) begin
            err_q <= !in_range;
            if (!rw) begin
              rvalid_q <= 1'b1;
              rdata_q  <= in_range ? rd_masked : '0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;
  assign ready  = ready_q;

endmodule

// File: tb/tb_ram_be_sync.sv
// Directed self-checking bench for ram_be_sync (DATA_W=32, DEPTH=256, clear sweep enabled).
module tb_ram_be_sync;

  logic        clock = 1'b0;
  logic        reset;
  logic        req;
  logic        rw;
  logic [31:0] addr;
  logic [3:0]  en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;
  logic        ready;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  ram_be_sync #(
    .DATA_W         (32),
    .DEPTH          (256),
    .ADDR_W         (32),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .rw     (rw),
    .addr   (addr),
    .en     (en),
    .wdata  (wdata),
    .rdata  (rdata),
    .rvalid (rvalid),
    .err    (err),
    .ready  (ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one request for a single edge, then drop req; outputs are sampled 1 after the edge.
  task automatic access(input logic w, input logic [31:0] a, input logic [3:0] e,
                        input logic [31:0] d);
    req = 1'b1; rw = w; addr = a; en = e; wdata = d;
    tick();
    req = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] a, input logic [3:0] e,
                          input logic [31:0] exp);
    access(1'b0, a, e, 32'h0);
    check({tag, "_rvalid"}, {31'b0, rvalid}, 32'd1);
    check({tag, "_err"}, {31'b0, err}, 32'd0);
    check({tag, "_rdata"}, rdata, exp);
  endtask

  // Counts edges after reset release until ready rises; bounded.
  task automatic wait_ready(input string tag, input int exp);
    int cnt = 0;
    while (!ready && cnt < 1000) begin
      tick();
      cnt++;
    end
    check(tag, cnt, exp);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; rw = 1'b0; addr = '0; en = '0; wdata = '0;
    tick();
    tick();
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_rvalid", {31'b0, rvalid}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_rdata", rdata, 32'h0);

    // 1: sweep takes exactly 256 edges, then memory reads as zero
    reset = 1'b0;
    wait_ready("t1_ready_cycles", 256);
    read_chk("t1_rd0", 32'd0, 4'hF, 32'h0);
    read_chk("t1_rd10", 32'd10, 4'hF, 32'h0);
    read_chk("t1_rd255", 32'd255, 4'hF, 32'h0);
    tick();
    check("t1_rvalid_pulse", {31'b0, rvalid}, 32'd0);

    // 2: full-word write and readback
    access(1'b1, 32'd0, 4'hF, 32'hF099810F);
    check("t2_wr_rvalid", {31'b0, rvalid}, 32'd0);
    check("t2_wr_err", {31'b0, err}, 32'd0);
    read_chk("t2_rd0", 32'd0, 4'hF, 32'hF099810F);
    tick();
    check("t2_rdata_hold", rdata, 32'hF099810F);

    // 3: partial-lane write and masked reads
    access(1'b1, 32'd10, 4'hF, 32'h01010101);
    access(1'b1, 32'd10, 4'b0010, 32'h0000AB00);
    read_chk("t3_rd_full", 32'd10, 4'hF, 32'h0101AB01);
    read_chk("t3_rd_lane0", 32'd10, 4'b0001, 32'h00000001);
    access(1'b1, 32'd10, 4'b0000, 32'hFFFFFFFF);
    read_chk("t3_rd_en0_nop", 32'd10, 4'hF, 32'h0101AB01);

    // 4: out-of-range write and read
    access(1'b1, 32'd256, 4'hF, 32'hFFFFFFFF);
    check("t4_wr_err", {31'b0, err}, 32'd1);
    check("t4_wr_rvalid", {31'b0, rvalid}, 32'd0);
    read_chk("t4_rd0_intact", 32'd0, 4'hF, 32'hF099810F);
    access(1'b0, 32'h8000_0000, 4'hF, 32'h0);
    check("t4_oor_rvalid", {31'b0, rvalid}, 32'd1);
    check("t4_oor_err", {31'b0, err}, 32'd1);
    check("t4_oor_rdata", rdata, 32'h0);
    tick();
    check("t4_err_pulse", {31'b0, err}, 32'd0);

    // 5: back-to-back write then read of the same word
    access(1'b1, 32'd255, 4'hF, 32'h0000029A);
    access(1'b0, 32'd255, 4'hF, 32'h0);
    check("t5_rvalid", {31'b0, rvalid}, 32'd1);
    check("t5_rdata", rdata, 32'h0000029A);

    // 6: reset mid-sweep restarts it; requests during the sweep are dropped
    access(1'b1, 32'd5, 4'hF, 32'hCAFEBABE);
    read_chk("t6_pre_rd5", 32'd5, 4'hF, 32'hCAFEBABE);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (100) tick();
    check("t6_mid_ready", {31'b0, ready}, 32'd0);
    reset = 1'b1;
    tick();
    check("t6_rst_rdata", rdata, 32'h0);
    reset = 1'b0;
    req = 1'b1; rw = 1'b1; addr = 32'd5; en = 4'hF; wdata = 32'h12345678;
    tick();
    req = 1'b0;
    check("t6_clr_rvalid", {31'b0, rvalid}, 32'd0);
    check("t6_clr_err", {31'b0, err}, 32'd0);
    wait_ready("t6_ready_cycles", 255);
    read_chk("t6_rd5", 32'd5, 4'hF, 32'h0);
    read_chk("t6_rd0", 32'd0, 4'hF, 32'h0);
    read_chk("t6_rd255", 32'd255, 4'hF, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
